ysyx_23060136_ifu_bht: RTL and testbench

//  Branch history table + target buffer; consumes the EXU2 branch-resolution update (pc, pre_true, pre_false).

---
 rtl/ysyx_23060136_ifu_bht.sv | 107 ++++++++++
 tb/tb_ysyx_23060136_ifu_bht.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060136_ifu_bht.sv
// Direct-mapped branch history table + target buffer for B-type branches.
// Ports: clk/rst; IFU_pc lookup -> BHT_pre_take/BHT_pre_target (combinational);
//   EXU2 resolution update (EXU2_stall, UPD_*); BHT_hit_cnt/BHT_alloc_cnt statistics.
module ysyx_23060136_ifu_bht #(
  parameter int BITS_W  = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_W-1:0] IFU_pc,
  output logic              BHT_pre_take,
  output logic [BITS_W-1:0] BHT_pre_target,
  input  logic              EXU2_stall,
  input  logic [BITS_W-1:0] UPD_pc,
  input  logic              UPD_pre_true,
  input  logic              UPD_pre_false,
  input  logic              UPD_pre_take,
  input  logic [BITS_W-1:0] UPD_target,
  output logic [BITS_W-1:0] BHT_hit_cnt,
  output logic [BITS_W-1:0] BHT_alloc_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [BITS_W-1:0]  tgt_q [ENTRIES];
  logic [BITS_W-1:0]  hit_cnt_q;
  logic [BITS_W-1:0]  alloc_cnt_q;

  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              r_hit;
  logic [IDX_W-1:0]  u_idx;
  logic [TAG_W-1:0]  u_tag;
  logic              u_hit;
  logic              u_en;
  logic              u_taken;
  logic [1:0]        ctr_d;
  logic [BITS_W-1:0] tgt_d;

  // Only the index/tag fields of the pcs matter; the rest is ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IFU_pc, UPD_pc};

  // Lookup reads the registered table only: a same-cycle update is
  // not bypassed, so IFU sees the pre-update entry.
  always_comb begin
    r_idx = IFU_pc[IDX_W+1:2];
    r_tag = IFU_pc[TAG_LO+TAG_W-1:TAG_LO];
    r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    BHT_pre_take   = r_hit && ctr_q[r_idx][1];
    BHT_pre_target = BHT_pre_take ? tgt_q[r_idx] : '0;
  end

  // With both pre_true and pre_false raised, the XOR makes
  // pre_false decide the direction.
  always_comb begin
    u_idx   = UPD_pc[IDX_W+1:2];
    u_tag   = UPD_pc[TAG_LO+TAG_W-1:TAG_LO];
    u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_en    = !EXU2_stall && (UPD_pre_true || UPD_pre_false);
    u_taken = UPD_pre_take ^ UPD_pre_false;
    ctr_d   = u_taken ? 2'b10 : 2'b01;
    tgt_d   = u_taken ? UPD_target : '0;
    if (u_hit) begin
      if (u_taken) begin
        ctr_d = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
      end else begin
        ctr_d = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        tgt_d = tgt_q[u_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      hit_cnt_q   <= '0;
      alloc_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= 2'b01;
        tgt_q[i] <= '0;
      end
    end else if (u_en) begin
      assert (!(UPD_pre_true && UPD_pre_false))
        else $error("bht: pre_true and pre_false both set");
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      ctr_q[u_idx]   <= ctr_d;
      tgt_q[u_idx]   <= tgt_d;
      if (u_hit) begin
        hit_cnt_q <= hit_cnt_q + BITS_W'(1);
      end else begin
        alloc_cnt_q <= alloc_cnt_q + BITS_W'(1);
      end
    end
  end

  assign BHT_hit_cnt   = hit_cnt_q;
  assign BHT_alloc_cnt = alloc_cnt_q;

endmodule

// File: tb/tb_ysyx_23060136_ifu_bht.sv
// Bench for ysyx_23060136_ifu_bht: directed vector table plus
// randomized traffic against a behavioural table model.
module tb_ysyx_23060136_ifu_bht;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IFU_pc = '0;
  logic        BHT_pre_take;
  logic [31:0] BHT_pre_target;
  logic        EXU2_stall = 1'b0;
  logic [31:0] UPD_pc = '0;
  logic        UPD_pre_true = 1'b0;
  logic        UPD_pre_false = 1'b0;
  logic        UPD_pre_take = 1'b0;
  logic [31:0] UPD_target = '0;
  logic [31:0] BHT_hit_cnt;
  logic [31:0] BHT_alloc_cnt;

  ysyx_23060136_ifu_bht dut (
    .clk(clk), .rst(rst),
    .IFU_pc(IFU_pc),
    .BHT_pre_take(BHT_pre_take),
    .BHT_pre_target(BHT_pre_target),
    .EXU2_stall(EXU2_stall),
    .UPD_pc(UPD_pc),
    .UPD_pre_true(UPD_pre_true),
    .UPD_pre_false(UPD_pre_false),
    .UPD_pre_take(UPD_pre_take),
    .UPD_target(UPD_target),
    .BHT_hit_cnt(BHT_hit_cnt),
    .BHT_alloc_cnt(BHT_alloc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, stall, pt, pf, ptake;
    logic [31:0] upc, utgt, ipc;
    bit          chk, etake;
    logic [31:0] etgt, ehit, ealloc;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // behavioural model state
  bit          m_valid [16];
  int          m_tag   [16];
  int          m_ctr   [16];
  logic [31:0] m_tgt   [16];
  logic [31:0] m_hits, m_allocs;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit s, bit pt, bit pf, bit tk,
      logic [31:0] upc, logic [31:0] utgt, logic [31:0] ipc, bit c,
      bit et, logic [31:0] eg, logic [31:0] eh, logic [31:0] ea);
    vec_t v;
    v.rst = r; v.stall = s; v.pt = pt; v.pf = pf; v.ptake = tk;
    v.upc = upc; v.utgt = utgt; v.ipc = ipc; v.chk = c;
    v.etake = et; v.etgt = eg; v.ehit = eh; v.ealloc = ea;
    return v;
  endfunction

  task automatic drive(input bit r, input bit s, input bit pt, input bit pf,
      input bit tk, input logic [31:0] upc, input logic [31:0] utgt,
      input logic [31:0] ipc);
    rst = r; EXU2_stall = s; UPD_pre_true = pt; UPD_pre_false = pf;
    UPD_pre_take = tk; UPD_pc = upc; UPD_target = utgt; IFU_pc = ipc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = '0;
    end
    m_hits = '0; m_allocs = '0;
  endtask

  task automatic model_update();
    int i, t;
    bit tk;
    if (rst) begin
      model_reset();
    end else if (!EXU2_stall && (UPD_pre_true || UPD_pre_false)) begin
      i  = int'((UPD_pc / 4) % 16);
      t  = int'((UPD_pc / 64) % 256);
      tk = UPD_pre_false ? !UPD_pre_take : UPD_pre_take;
      if (m_valid[i] && m_tag[i] == t) begin
        m_ctr[i] = tk ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                      : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
        if (tk) m_tgt[i] = UPD_target;
        m_hits = m_hits + 1;
      end else begin
        m_valid[i] = 1; m_tag[i] = t;
        m_ctr[i] = tk ? 2 : 1;
        m_tgt[i] = tk ? UPD_target : 32'h0;
        m_allocs = m_allocs + 1;
      end
    end
  endtask

  task automatic model_check();
    int i, t;
    bit tk;
    i  = int'((IFU_pc / 4) % 16);
    t  = int'((IFU_pc / 64) % 256);
    tk = m_valid[i] && m_tag[i] == t && m_ctr[i] >= 2;
    check("rnd_take", {31'd0, BHT_pre_take}, {31'd0, tk});
    check("rnd_target", BHT_pre_target, tk ? m_tgt[i] : 32'h0);
    check("rnd_hit_cnt", BHT_hit_cnt, m_hits);
    check("rnd_alloc_cnt", BHT_alloc_cnt, m_allocs);
  endtask

  localparam logic [31:0] P  = 32'h8000_0010;
  localparam logic [31:0] A  = 32'h8000_0050;
  localparam logic [31:0] T1 = 32'h8000_0100;
  localparam logic [31:0] T2 = 32'h8000_0200;
  localparam logic [31:0] Z  = 32'h0;

  initial begin
    // r s pt pf tk upc utgt ipc chk etake etgt ehit ealloc
    vecs.push_back(mk(1,0,0,0,0, Z,Z, P, 0, 0,Z, 0,0));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, P, 1, 0,Z, 0,0));
    vecs.push_back(mk(0,0,0,1,0, P,T1,P, 1, 0,Z, 0,0));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, P, 1, 1,T1,0,1));
    vecs.push_back(mk(0,0,1,0,1, P,T1,P, 1, 1,T1,0,1));
    vecs.push_back(mk(0,0,1,0,1, P,T1,P, 1, 1,T1,1,1));
    vecs.push_back(mk(0,0,1,0,0, P,Z, P, 1, 1,T1,2,1));
    vecs.push_back(mk(0,0,1,0,0, P,Z, P, 1, 1,T1,3,1));
    vecs.push_back(mk(0,0,1,0,0, P,Z, P, 1, 0,Z, 4,1));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, P, 1, 0,Z, 5,1));
    vecs.push_back(mk(0,0,1,0,1, A,T2,A, 1, 0,Z, 5,1));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, P, 1, 0,Z, 5,2));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, A, 1, 1,T2,5,2));
    vecs.push_back(mk(0,1,0,1,1, A,Z, A, 1, 1,T2,5,2));
    vecs.push_back(mk(0,1,0,1,1, A,Z, A, 1, 1,T2,5,2));
    vecs.push_back(mk(0,1,0,1,1, A,Z, A, 1, 1,T2,5,2));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, A, 1, 1,T2,5,2));
    vecs.push_back(mk(0,0,0,1,1, A,Z, A, 1, 1,T2,5,2));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, A, 1, 0,Z, 6,2));
    vecs.push_back(mk(1,0,1,0,1, A,T2,A, 1, 0,Z, 6,2));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, A, 1, 0,Z, 0,0));
    vecs.push_back(mk(0,0,1,0,1, A,T2,A, 1, 0,Z, 0,0));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, A, 1, 1,T2,0,1));
    vecs.push_back(mk(0,0,0,0,0, Z,Z, A|32'h3, 1, 1,T2,0,1));

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].stall, vecs[k].pt, vecs[k].pf,
            vecs[k].ptake, vecs[k].upc, vecs[k].utgt, vecs[k].ipc);
      #1;
      if (vecs[k].chk) begin
        check($sformatf("v%0d_take", k), {31'd0, BHT_pre_take},
              {31'd0, vecs[k].etake});
        check($sformatf("v%0d_target", k), BHT_pre_target, vecs[k].etgt);
        check($sformatf("v%0d_hit_cnt", k), BHT_hit_cnt, vecs[k].ehit);
        check($sformatf("v%0d_alloc_cnt", k), BHT_alloc_cnt,
              vecs[k].ealloc);
      end
    end

    // randomized phase, starting from a fresh reset
    @(negedge clk);
    drive(1, 0, 0, 0, 0, Z, Z, Z);
    @(posedge clk);
    model_update();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] upc, ipc;
      int kind;
      @(negedge clk);
      upc  = ($urandom & ~32'h3FC0) | ($urandom_range(0, 2) << 6);
      ipc  = ($urandom_range(0, 3) == 0) ? upc :
             (($urandom & ~32'h3FC0) | ($urandom_range(0, 2) << 6));
      kind = $urandom_range(0, 2);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
            kind == 1, kind == 2, $urandom_range(0, 1) == 1,
            upc, $urandom, ipc);
      #1;
      model_check();
      @(posedge clk);
      model_update();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
